// File: rtl/bus_pkg.sv
// Shared definitions for the serial system bus: arbiter state encoding,
// default master count and bus-wide constants used by the master and slave ports.
package bus_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  localparam int N_MASTERS_DEF = 2;

  localparam int BUS_ADDR_W  = 32;
  localparam int BUS_DATA_W  = 32;
  localparam int BUS_TRANS_W = 2;
  localparam int BUS_RESP_W  = 2;

endpackage

// File: rtl/bus_arbiter_if.sv
// Arbitration handshake bundle: master requests, grants, bus-mux select and
// the slave-side split controls.
interface bus_arbiter_if #(
  parameter int N_MASTERS = 2,
  parameter int MSEL_W    = $clog2(N_MASTERS)
);
  logic [N_MASTERS-1:0] breq;
  logic [N_MASTERS-1:0] bgrant;
  logic [N_MASTERS-1:0] split;
  logic [MSEL_W-1:0]    msel;
  logic                 bus_busy;
  logic                 sl_split;
  logic                 sl_split_done;
  logic                 split_busy;

  // Arbiter side drives grants and split status.
  modport master (
    input  breq, sl_split, sl_split_done,
    output bgrant, split, msel, bus_busy, split_busy
  );

  // Requestors and slaves see the opposite direction.
  modport slave (
    output breq, sl_split, sl_split_done,
    input  bgrant, split, msel, bus_busy, split_busy
  );
endinterface

// File: rtl/bus_arbiter_rr_picker.sv
// Combinational round-robin search: first set request strictly after last_i,
// wrapping modulo N_MASTERS.
module rr_picker #(
  parameter int N_MASTERS = 2,
  parameter int MSEL_W    = $clog2(N_MASTERS)
) (
  input  logic [N_MASTERS-1:0] req_i,
  input  logic [MSEL_W-1:0]    last_i,
  output logic [MSEL_W-1:0]    winner_o,
  output logic                 any_valid_o
);

  int idx;

  // Walk offsets from farthest to nearest so the nearest requester wins.
  always_comb begin
    winner_o    = '0;
    any_valid_o = |req_i;
    idx         = 0;
    for (int off = N_MASTERS; off >= 1; off--) begin
      idx = (int'(last_i) + off) % N_MASTERS;
      if (req_i[MSEL_W'(idx)]) winner_o = MSEL_W'(idx);
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin bus arbiter with one outstanding split transaction: the split
// master is parked and re-granted with priority once the slave is ready.
module bus_arbiter
  import bus_pkg::*;
#(
  parameter int N_MASTERS = N_MASTERS_DEF,
  parameter int MSEL_W    = $clog2(N_MASTERS)
) (
  input logic          clk,
  input logic          rstn,
  bus_arbiter_if.master bus
);

  localparam logic [0:0] ST_IDLE  = IDLE;
  localparam logic [0:0] ST_GRANT = GRANT;

  logic [0:0]           state_q, state_d;
  logic [MSEL_W-1:0]    last_q, last_d;
  logic [MSEL_W-1:0]    msel_q, msel_d;
  logic [N_MASTERS-1:0] bgrant_q, bgrant_d;
  logic [N_MASTERS-1:0] split_q, split_d;
  logic                 split_valid_q, split_valid_d;
  logic [MSEL_W-1:0]    split_owner_q, split_owner_d;
  logic                 resume_pend_q, resume_pend_d;
  logic                 bus_busy_q, split_busy_q;

  logic [N_MASTERS-1:0] park_mask;
  logic [N_MASTERS-1:0] eligible;
  logic [MSEL_W-1:0]    winner;
  logic                 any_valid;

  always_comb begin
    park_mask = '0;
    if (split_valid_q && !resume_pend_q) park_mask[split_owner_q] = 1'b1;
  end

  assign eligible = bus.breq & ~park_mask;

  rr_picker #(.N_MASTERS(N_MASTERS), .MSEL_W(MSEL_W)) u_picker (
    .req_i      (eligible),
    .last_i     (last_q),
    .winner_o   (winner),
    .any_valid_o(any_valid)
  );

  always_comb begin
    state_d       = state_q;
    last_d        = last_q;
    msel_d        = msel_q;
    bgrant_d      = bgrant_q;
    split_d       = split_q;
    split_valid_d = split_valid_q;
    split_owner_d = split_owner_q;
    resume_pend_d = resume_pend_q;

    // split_valid_q is still low in the capture cycle, so a same-cycle done is dropped.
    if (bus.sl_split_done && split_valid_q) resume_pend_d = 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (resume_pend_q && bus.breq[split_owner_q]) begin
          bgrant_d                = '0;
          bgrant_d[split_owner_q] = 1'b1;
          split_d                 = '0;
          split_valid_d           = 1'b0;
          resume_pend_d           = 1'b0;
          msel_d                  = split_owner_q;
          state_d                 = ST_GRANT;
        end else if (any_valid) begin
          bgrant_d         = '0;
          bgrant_d[winner] = 1'b1;
          msel_d           = winner;
          state_d          = ST_GRANT;
        end
      end
      ST_GRANT: begin
        if (!bus.breq[msel_q]) begin
          bgrant_d = '0;
          last_d   = msel_q;
          state_d  = ST_IDLE;
        end else if (bus.sl_split && !split_valid_q) begin
          split_owner_d   = msel_q;
          split_valid_d   = 1'b1;
          split_d         = '0;
          split_d[msel_q] = 1'b1;
          bgrant_d        = '0;
          last_d          = msel_q;
          state_d         = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q       <= ST_IDLE;
      last_q        <= MSEL_W'(N_MASTERS - 1);
      msel_q        <= '0;
      bgrant_q      <= '0;
      split_q       <= '0;
      split_valid_q <= 1'b0;
      split_owner_q <= '0;
      resume_pend_q <= 1'b0;
      bus_busy_q    <= 1'b0;
      split_busy_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      last_q        <= last_d;
      msel_q        <= msel_d;
      bgrant_q      <= bgrant_d;
      split_q       <= split_d;
      split_valid_q <= split_valid_d;
      split_owner_q <= split_owner_d;
      resume_pend_q <= resume_pend_d;
      bus_busy_q    <= |bgrant_d;
      split_busy_q  <= split_valid_d;
    end
  end

  assign bus.bgrant     = bgrant_q;
  assign bus.split      = split_q;
  assign bus.msel       = msel_q;
  assign bus.bus_busy   = bus_busy_q;
  assign bus.split_busy = split_busy_q;

  a_grant_onehot: assert property (@(posedge clk) disable iff (!rstn) $onehot0(bgrant_q));
  a_split_onehot: assert property (@(posedge clk) disable iff (!rstn) $onehot0(split_q));
  a_no_overlap:   assert property (@(posedge clk) disable iff (!rstn) (bgrant_q & split_q) == '0);
  a_busy:         assert property (@(posedge clk) disable iff (!rstn) bus_busy_q == |bgrant_q);
  a_split_busy:   assert property (@(posedge clk) disable iff (!rstn) split_busy_q == split_valid_q);

endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
- Shares the serial system bus among N_MASTERS master ports using the breq/bgrant handshake.
- Picks the next owner round-robin.
- Drives the master-select for the bus mux.
- Manages one outstanding split transaction: the split master is parked, the bus is given to others, and the split master is re-granted with priority once the slave reports it is ready.

Parameters:
- N_MASTERS, 2, number of master ports; legal range 2..8.
- MSEL_W, $clog2(N_MASTERS), width of msel.

Ports:
- clk  in  1  system clock.
- rstn  in  1  reset; one clock, synchronous, active-low.
- breq  in  N_MASTERS  per-master bus request (level).
- bgrant  out  N_MASTERS  per-master grant; one-hot or zero.
- split  out  N_MASTERS  per-master split indication; at most one bit high.
- msel  out  MSEL_W  index of the current owner; drives the bus mux.
- bus_busy  out  1  high while any bgrant bit is high.
- sl_split  in  1  the addressed slave requests a split of the current transaction (level, sampled in GRANT).
- sl_split_done  in  1  one-cycle pulse: the split slave is ready to resume.
- split_busy  out  1  high while a split is outstanding; slaves must not split while this is high.

Behaviour:

Registers and reset:
- All outputs are registered.
- When rstn=0 at a clock edge, the next state is:
  - bgrant=0, split=0, msel=0, bus_busy=0, split_busy=0.
  - state=IDLE; last_owner=N_MASTERS-1, so master 0 wins first.
  - split_valid=0, split_owner=0, resume_pend=0.
- Reset mid-transaction drops grant and split immediately and discards any outstanding split.

State machine, states IDLE and GRANT:

IDLE:
- Eligible set = breq & ~park_mask, where park_mask = onehot(split_owner) if split_valid & ~resume_pend, else 0.
- If resume_pend and breq[split_owner] are both high:
  - winner = split_owner.
  - Next cycle: bgrant[winner]=1 and split[winner]=0 together.
  - split_valid, resume_pend and split_busy all clear.
- Else, if the eligible set is non-zero:
  - winner = first set bit searching from last_owner+1 upward, wrapping modulo N_MASTERS.
  - Next cycle: bgrant[winner]=1, msel=winner, state=GRANT.
- Else: stay in IDLE with msel unchanged.
- Grant latency: request seen in IDLE at cycle t gives bgrant at t+1.

GRANT:
- owner = msel.
- If breq[owner]=0:
  - Next cycle: bgrant=0, last_owner=owner, state=IDLE.
  - There is always at least one idle cycle between owners, so no back-to-back handover.
- Else, if sl_split=1 and split_valid=0:
  - Capture split_owner=owner and set split_valid=1.
  - Next cycle: split[owner]=1, bgrant=0, split_busy=1, last_owner=owner, state=IDLE.
- Else, if sl_split=1 and split_valid=1: ignore sl_split (protocol violation by the slave) and stay in GRANT.
- Otherwise: hold the grant; there is no arbiter-side timeout.

Split handling:
- split[split_owner] stays high from capture until the re-grant cycle.
- The parked master keeps breq high while it waits.
- sl_split_done with split_valid=1 sets resume_pend=1.
  - It is honoured only in IDLE, after the current owner releases.
  - Ownership is never pre-empted.
- sl_split_done with split_valid=0 is ignored.
- sl_split_done arriving in the same cycle as split capture is ignored; it must arrive strictly after capture.
- If breq[split_owner] is low at resume time: wait, and keep parking the other masters' priority lower than the resumer.

Simultaneous events:
- breq[owner] falling in the same cycle as sl_split: release wins and the split is not captured.
- Multiple requests in IDLE: round-robin picks exactly one winner.
- New requests during GRANT are queued implicitly by their level breq.

Invariants (assertions):
- $onehot0(bgrant) and $onehot0(split).
- (bgrant & split) == 0.
- bus_busy == |bgrant.
- split_busy == split_valid.

Decomposition:
- Package bus_pkg holds:
  - arb_state_t enum {IDLE, GRANT}.
  - Default constant N_MASTERS_DEF = 2.
  - Shared bus constants used by master_port and the slave ports.
- One sub-module, rr_picker:
  - Combinational round-robin search.
  - Inputs: req vector, last index.
  - Outputs: winner index, any_valid.
  - Parameterised by N_MASTERS.
- FSM, split bookkeeping and output registers stay in bus_arbiter.

Test Plan:
1. Reset, then breq=01 held: bgrant=01 one cycle later, msel=0, bus_busy=1. Drop breq: bgrant=00 next cycle.
2. N=2, breq=11 held continuously, each owner drops breq for one cycle after 10-cycle transactions: grants alternate 01,10,01,10 with one idle cycle between each.
3. Master 0 granted, sl_split=1 for one cycle: split=01, bgrant=00, split_busy=1. Master 1 (breq=10) is granted within 2 cycles while master 0 holds breq.
4. During master 1's grant, pulse sl_split_done: master 1 is not pre-empted. After master 1 drops breq: bgrant=01 and split=00 in the same cycle, split_busy=0.
5. Split outstanding and master 1 granted with sl_split=1: ignored, bgrant=10 held, split stays 01.
6. rstn=0 mid-grant with a split outstanding: next cycle bgrant=0, split=0, split_busy=0. After release with breq=11, master 0 is granted first.
